// File: rtl/hex_syscall_unit_pkg.sv
// rtl/hex_syscall_unit_pkg.sv - shared types for the Hex SVC responder
package hex_syscall_unit_pkg;

  typedef enum logic [1:0] {
    SYS_EXIT    = 2'd0,
    SYS_WRITE   = 2'd1,
    SYS_READ    = 2'd2,
    SYS_INVALID = 2'd3
  } syscall_t;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE_TX,
    ST_READ_RX,
    ST_RESP,
    ST_HALTED
  } syscall_state_t;

  localparam logic [31:0] SYSCALL_EOF = 32'hFFFF_FFFF;

endpackage

// File: rtl/hex_syscall_unit_if.sv
// rtl/hex_syscall_unit_if.sv - SVC request/response channel plus TX/RX byte streams
interface hex_syscall_unit_if #(
  parameter int STREAM_WIDTH = 8
) ();

  logic                    i_req_valid;
  logic                    o_req_ready;
  logic [1:0]              i_req_opc;
  logic [31:0]             i_req_arg0;
  logic [31:0]             i_req_arg1;
  logic                    o_rsp_valid;
  logic                    i_rsp_ready;
  logic [31:0]             o_rsp_data;
  logic                    o_tx_valid;
  logic                    i_tx_ready;
  logic [7:0]              o_tx_data;
  logic [STREAM_WIDTH-1:0] o_tx_stream;
  logic                    i_rx_valid;
  logic                    o_rx_ready;
  logic [7:0]              i_rx_data;
  logic [STREAM_WIDTH-1:0] o_rx_stream;
  logic                    o_halt;
  logic [31:0]             o_exit_code;
  logic                    o_err;

  // Responder side: the syscall unit itself
  modport slave (
    input  i_req_valid, i_req_opc, i_req_arg0, i_req_arg1, i_rsp_ready,
           i_tx_ready, i_rx_valid, i_rx_data,
    output o_req_ready, o_rsp_valid, o_rsp_data, o_tx_valid, o_tx_data,
           o_tx_stream, o_rx_ready, o_rx_stream, o_halt, o_exit_code, o_err
  );

  // Initiator side: core issue logic together with host I/O
  modport master (
    output i_req_valid, i_req_opc, i_req_arg0, i_req_arg1, i_rsp_ready,
           i_tx_ready, i_rx_valid, i_rx_data,
    input  o_req_ready, o_rsp_valid, o_rsp_data, o_tx_valid, o_tx_data,
           o_tx_stream, o_rx_ready, o_rx_stream, o_halt, o_exit_code, o_err
  );

endinterface

// File: rtl/hex_syscall_unit.sv
// rtl/hex_syscall_unit.sv - services EXIT/WRITE/READ syscalls, bridging them onto byte streams
module hex_syscall_unit
  import hex_syscall_unit_pkg::*;
#(
  parameter int STREAM_WIDTH = 8,
  parameter int READ_TIMEOUT = 0
) (
  input logic                i_clk,
  input logic                i_rst,
  hex_syscall_unit_if.slave  svc
);

  localparam bit TO_EN = (READ_TIMEOUT > 0);
  localparam int CNT_W = TO_EN ? $clog2(READ_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_EN ? READ_TIMEOUT - 1 : 0);

  syscall_state_t          state_q;
  byte_t                   tx_data_q;
  logic [STREAM_WIDTH-1:0] tx_stream_q;
  logic [STREAM_WIDTH-1:0] rx_stream_q;
  logic [31:0]             rsp_data_q;
  logic                    halt_q;
  logic [31:0]             exit_code_q;
  logic                    err_q;
  logic [CNT_W-1:0]        rd_cnt_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      tx_data_q   <= '0;
      tx_stream_q <= '0;
      rx_stream_q <= '0;
      rsp_data_q  <= '0;
      halt_q      <= 1'b0;
      exit_code_q <= '0;
      err_q       <= 1'b0;
      rd_cnt_q    <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (svc.i_req_valid) begin
            case (svc.i_req_opc)
              SYS_EXIT: begin
                exit_code_q <= svc.i_req_arg0;
                halt_q      <= 1'b1;
                state_q     <= ST_HALTED;
              end
              SYS_WRITE: begin
                tx_data_q   <= svc.i_req_arg0[7:0];
                tx_stream_q <= svc.i_req_arg1[STREAM_WIDTH-1:0];
                state_q     <= ST_WRITE_TX;
              end
              SYS_READ: begin
                rx_stream_q <= svc.i_req_arg1[STREAM_WIDTH-1:0];
                rd_cnt_q    <= '0;
                state_q     <= ST_READ_RX;
              end
              default: begin
                err_q      <= 1'b1;
                rsp_data_q <= SYSCALL_EOF;
                state_q    <= ST_RESP;
              end
            endcase
          end
        end
        ST_WRITE_TX: begin
          if (svc.i_tx_ready) begin
            rsp_data_q <= '0;
            state_q    <= ST_RESP;
          end
        end
        ST_READ_RX: begin
          // An arriving byte takes priority over an expiring timeout
          if (svc.i_rx_valid) begin
            rsp_data_q <= {24'b0, svc.i_rx_data};
            state_q    <= ST_RESP;
          end else if (TO_EN && (rd_cnt_q == TO_LAST)) begin
            rsp_data_q <= SYSCALL_EOF;
            state_q    <= ST_RESP;
          end else if (TO_EN) begin
            rd_cnt_q <= rd_cnt_q + 1'b1;
          end
        end
        ST_RESP: begin
          if (svc.i_rsp_ready) begin
            state_q <= ST_IDLE;
          end
        end
        ST_HALTED: begin
          state_q <= ST_HALTED;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign svc.o_req_ready = (state_q == ST_IDLE);
  assign svc.o_tx_valid  = (state_q == ST_WRITE_TX);
  assign svc.o_rx_ready  = (state_q == ST_READ_RX);
  assign svc.o_rsp_valid = (state_q == ST_RESP);
  assign svc.o_rsp_data  = rsp_data_q;
  assign svc.o_tx_data   = tx_data_q;
  assign svc.o_tx_stream = tx_stream_q;
  assign svc.o_rx_stream = rx_stream_q;
  assign svc.o_halt      = halt_q;
  assign svc.o_exit_code = exit_code_q;
  assign svc.o_err       = err_q;

endmodule

// File: tb/tb_hex_syscall_unit.sv
// tb/tb_hex_syscall_unit.sv - scoreboard bench for hex_syscall_unit
module tb_hex_syscall_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] rsp_exp[$];
  logic [15:0] tx_exp[$];

  always #5 clk = ~clk;

  hex_syscall_unit_if #(.STREAM_WIDTH(8)) bus ();

  hex_syscall_unit #(.STREAM_WIDTH(8), .READ_TIMEOUT(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .svc   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: pop and compare on each completed handshake
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_rsp_valid && bus.i_rsp_ready) begin
        if (rsp_exp.size() == 0) chk("rsp_unexpected", bus.o_rsp_data, 32'hDEAD);
        else chk("rsp_data", bus.o_rsp_data, rsp_exp.pop_front());
      end
      if (bus.o_tx_valid && bus.i_tx_ready) begin
        if (tx_exp.size() == 0) chk("tx_unexpected", {16'b0, bus.o_tx_stream, bus.o_tx_data}, 32'hDEAD);
        else chk("tx_byte", {16'b0, bus.o_tx_stream, bus.o_tx_data}, {16'b0, tx_exp.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] opc, input logic [31:0] a0, input logic [31:0] a1);
    bit ok = 0;
    bus.i_req_valid = 1'b1;
    bus.i_req_opc   = opc;
    bus.i_req_arg0  = a0;
    bus.i_req_arg1  = a1;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (bus.o_req_ready) ok = 1;
      @(posedge clk);
      #1;
    end
    bus.i_req_valid = 1'b0;
    bus.i_req_opc   = 2'($urandom);
    bus.i_req_arg0  = $urandom;
    bus.i_req_arg1  = $urandom;
    if (!ok) chk("req_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!bus.o_req_ready && n < 20) begin
      step();
      n++;
    end
    if (n == 20) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int cnt;
    bus.i_req_valid = 0; bus.i_req_opc = 0; bus.i_req_arg0 = 0; bus.i_req_arg1 = 0;
    bus.i_rsp_ready = 0; bus.i_tx_ready = 0; bus.i_rx_valid = 0; bus.i_rx_data = 0;
    step(); step();
    chk("rst_req_ready", bus.o_req_ready, 1);
    chk("rst_outputs", {bus.o_tx_valid, bus.o_rx_ready, bus.o_rsp_valid, bus.o_halt, bus.o_err}, 0);
    chk("rst_rsp_data", bus.o_rsp_data, 0);
    chk("rst_exit_code", bus.o_exit_code, 0);
    rst = 1'b0;
    step();

    // WRITE with junk above the byte, sink always ready
    bus.i_tx_ready = 1; bus.i_rsp_ready = 1;
    tx_exp.push_back({8'd1, 8'h41}); rsp_exp.push_back(32'd0);
    issue(2'd1, 32'h141, 32'h1);
    chk("w1_tx_valid_n1", bus.o_tx_valid, 1);
    chk("w1_tx_data", bus.o_tx_data, 32'h41);
    chk("w1_tx_stream", bus.o_tx_stream, 32'h1);
    step();
    chk("w1_rsp_valid_n2", bus.o_rsp_valid, 1);
    step();
    chk("w1_idle_after", bus.o_req_ready, 1);

    // WRITE with back-pressure for 5 cycles
    bus.i_tx_ready = 0;
    tx_exp.push_back({8'd3, 8'hC5}); rsp_exp.push_back(32'd0);
    issue(2'd1, 32'hFFFF_FFC5, 32'h0000_0103);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("w2_hold%0d", i), {bus.o_tx_valid, 7'b0, bus.o_tx_stream, bus.o_tx_data}, {1'b1, 7'b0, 8'd3, 8'hC5});
      step();
    end
    bus.i_tx_ready = 1;
    step();
    chk("w2_rsp_after_tx", {bus.o_rsp_valid, bus.o_tx_valid}, 2'b10);
    wait_idle();

    // READ stream 0, byte arrives later, response held under back-pressure
    bus.i_rsp_ready = 0;
    issue(2'd2, 32'h0, 32'h0);
    chk("r1_rx_ready", {bus.o_rx_ready, bus.o_rx_stream}, {1'b1, 8'd0});
    step(); step();
    bus.i_rx_valid = 1; bus.i_rx_data = 8'h7A;
    step();
    bus.i_rx_valid = 0; bus.i_rx_data = 8'h00;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("r1_rsp_hold%0d", i), bus.o_rsp_valid ? bus.o_rsp_data : 32'hBAD0BAD0, 32'h7A);
      step();
    end
    rsp_exp.push_back(32'h7A);
    bus.i_rsp_ready = 1;
    step();
    wait_idle();

    // READ timeout with no byte: four waiting cycles then EOF
    rsp_exp.push_back(32'hFFFF_FFFF);
    issue(2'd2, 32'h0, 32'h5);
    chk("r2_rx_stream", bus.o_rx_stream, 32'h5);
    cnt = 0;
    for (int n = 0; n < 20 && !bus.o_rsp_valid; n++) begin
      if (bus.o_rx_ready) cnt++;
      step();
    end
    chk("r2_timeout_cycles", cnt, 4);
    wait_idle();

    // Byte arrives exactly on the timeout cycle: byte wins
    rsp_exp.push_back(32'h55);
    issue(2'd2, 32'h0, 32'h2);
    step(); step(); step();
    bus.i_rx_valid = 1; bus.i_rx_data = 8'h55;
    step();
    bus.i_rx_valid = 0;
    chk("r3_rsp_at_timeout", {bus.o_rsp_valid, bus.o_rsp_data}, {1'b1, 32'h55});
    wait_idle();

    // Invalid opcode: one-cycle err pulse, EOF response
    rsp_exp.push_back(32'hFFFF_FFFF);
    issue(2'd3, 32'h1234, 32'h0);
    chk("inv_err_pulse", {bus.o_err, bus.o_rsp_valid}, 2'b11);
    step();
    chk("inv_err_clear", bus.o_err, 0);
    wait_idle();

    // Async reset in WRITE_TX discards the pending byte
    bus.i_tx_ready = 0;
    issue(2'd1, 32'h99, 32'h2);
    chk("rw_tx_valid", bus.o_tx_valid, 1);
    rst = 1;
    #1;
    chk("rw_async_drop", {bus.o_tx_valid, bus.o_req_ready, bus.o_tx_data}, {1'b0, 1'b1, 8'h00});
    step();
    rst = 0;
    bus.i_tx_ready = 1;
    step();
    chk("rw_idle_after", {bus.o_req_ready, bus.o_tx_valid, bus.o_rsp_valid}, 3'b100);

    // EXIT halts permanently with no response
    issue(2'd0, 32'h2A, 32'h0);
    chk("exit_halt", {bus.o_halt, bus.o_req_ready}, 2'b10);
    chk("exit_code", bus.o_exit_code, 32'h2A);
    bus.i_req_valid = 1; bus.i_req_opc = 2'd1; bus.i_req_arg0 = 32'h33;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.o_req_ready || bus.o_rsp_valid || bus.o_tx_valid || !bus.o_halt) cnt++;
      step();
    end
    bus.i_req_valid = 0;
    chk("halt_ignores_reqs", cnt, 0);
    chk("sb_rsp_drained", rsp_exp.size(), 0);
    chk("sb_tx_drained", tx_exp.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
